fp_mul_pipe: RTL

//  Parametrised IEEE-754-style floating-point multiplier, 3-stage pipeline with valid/ready handshake.

---
 rtl/fp_mul_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// Parametrised IEEE-754-style multiplier: 3-stage pipeline (classify / multiply / normalise-round-pack).
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even, otherwise truncate (round toward zero).
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [3:0]             flags
);

  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int LZW  = $clog2(PW + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

  typedef enum logic [1:0] {CLS_FINITE, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

  typedef struct packed {
    logic                 s;
    cls_e                 cls;
    logic signed [EW-1:0] e;
  } ctl_t;

  // ---------------- Stage 1: unpack / classify ----------------
  logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic [MW-1:0]    w_ma, w_mb;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic             w_advance;
  ctl_t             w_ctl1;

  assign w_ea = a[FW-2:MAN_W];
  assign w_eb = b[FW-2:MAN_W];
  assign w_fa = a[MAN_W-1:0];
  assign w_fb = b[MAN_W-1:0];

  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_a_inf  = (&w_ea) && !(|w_fa);
  assign w_b_inf  = (&w_eb) && !(|w_fb);
  assign w_a_zero = !(|w_ea) && !(|w_fa);
  assign w_b_zero = !(|w_eb) && !(|w_fb);

  // Subnormal operands have no hidden bit but share the exponent of the smallest normal.
  assign w_ma     = {|w_ea, w_fa};
  assign w_mb     = {|w_eb, w_fb};
  assign w_ea_eff = (|w_ea) ? w_ea : EXP_W'(1);
  assign w_eb_eff = (|w_eb) ? w_eb : EXP_W'(1);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    w_ctl1.s   = a[FW-1] ^ b[FW-1];
    w_ctl1.e   = EW'(w_ea_eff) + EW'(w_eb_eff) - EW'(BIAS);
    w_ctl1.cls = CLS_FINITE;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
      w_ctl1.cls = CLS_NAN;
    else if (w_a_inf || w_b_inf)
      w_ctl1.cls = CLS_INF;
    else if (w_a_zero || w_b_zero)
      w_ctl1.cls = CLS_ZERO;
  end

  // Global stall: everything moves together whenever the output slot is free or being drained.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------- Pipeline registers ----------------
  logic          r_v1, r_v2, r_out_valid;
  ctl_t          r_ctl1, r_ctl2;
  logic [MW-1:0] r_ma1, r_mb1;
  logic [PW-1:0] r_p2;
  logic [FW-1:0] r_c, w_c;
  logic [3:0]    r_flags, w_flags;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_flags     <= '0;
    end else if (w_advance) begin
      r_v1        <= in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_c     <= w_c;
        r_flags <= w_flags;
      end
    end
  end

  // NOTE: datapath registers carry no reset; their contents are only ever used under a set valid bit.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      if (in_valid) begin
        r_ctl1 <= w_ctl1;
        r_ma1  <= w_ma;
        r_mb1  <= w_mb;
      end
      if (r_v1) begin
        r_ctl2 <= r_ctl1;
        r_p2   <= PW'(r_ma1) * PW'(r_mb1);
      end
    end
  end

  // ---------------- Stage 3: normalise / round / pack ----------------
  function automatic logic [LZW-1:0] count_lz(input logic [PW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(PW);
    for (int i = 0; i < PW; i++)
      if (v[i]) n = LZW'(PW - 1 - i);
    return n;
  endfunction

  logic [LZW-1:0]       w_lz;
  logic [PW-2:0]        w_norm;
  logic [MAN_W-1:0]     w_man;
  logic                 w_guard, w_sticky, w_rnd_up;
  logic [MAN_W:0]       w_man_sum;
  logic signed [EW-1:0] w_e_n, w_e_r;
  logic [FW-1:0]        w_ovf_c;

  // After the shift the leading one sits at bit PW-1 (dropped); exponent is e+1-lz.
  assign w_lz     = count_lz(r_p2);
  assign w_norm   = (PW-1)'(r_p2 << w_lz);
  assign w_e_n    = r_ctl2.e + EW'(1) - EW'(w_lz);
  assign w_man    = w_norm[PW-2 -: MAN_W];
  assign w_guard  = w_norm[MAN_W];
  assign w_sticky = |w_norm[MAN_W-1:0];

`ifdef FP_MUL_RNE_EN
  assign w_rnd_up = w_guard && (w_sticky || w_man[0]);
  assign w_ovf_c  = {r_ctl2.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
  assign w_rnd_up = 1'b0;
  assign w_ovf_c  = {r_ctl2.s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif

  // A carry out of the mantissa leaves it all-zero, i.e. 1.0 at the next exponent.
  assign w_man_sum = {1'b0, w_man} + (MAN_W+1)'(w_rnd_up);
  assign w_e_r     = w_e_n + EW'(w_man_sum[MAN_W]);

  always_comb begin
    w_c     = '0;
    w_flags = '0;
    case (r_ctl2.cls)
      CLS_NAN: begin
        w_c     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        w_flags = 4'b1000;
      end
      CLS_INF:  w_c = {r_ctl2.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: w_c = {r_ctl2.s, {(FW-1){1'b0}}};
      CLS_FINITE: begin
        if (w_e_r >= EMAX_S) begin
          w_c     = w_ovf_c;
          w_flags = 4'b0101;
        end else if (w_e_r[EW-1] || (w_e_r == '0)) begin
          w_c     = {r_ctl2.s, {(FW-1){1'b0}}};
          w_flags = 4'b0011;
        end else begin
          w_c     = {r_ctl2.s, w_e_r[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
          w_flags = {3'b000, w_guard | w_sticky};
        end
      end
      default: ;
    endcase
  end

  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign flags     = r_flags;

endmodule
